// File: rtl/pixel_block_assembler_pkg.sv
// Shared pixel/block definitions for the watermark front end: lane order of a
// 2x2 block, default image geometry and a width helper.
package pixel_block_assembler_pkg;

  localparam int DEF_PIX_W      = 8;
  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;

  // Lane order of a 2x2 block as presented on Data1..Data4.
  localparam int BLK_TL = 0;
  localparam int BLK_TR = 1;
  localparam int BLK_BL = 2;
  localparam int BLK_BR = 3;

  // Index width that never collapses to zero for tiny images.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_block_assembler_pair_line_buf.sv
// Pair line buffer: one entry per horizontal pixel pair of an even row,
// synchronous write, asynchronous read.
module pair_line_buf #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every entry is written on the even row before
  // the odd row reads it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_block_assembler.sv
// Regroups a raster pixel stream into non-overlapping 2x2 blocks for watermark
// insertion. Define PBA_BLOCK_INDEX_EN to add the raster block-number output.
module pixel_block_assembler
  import pixel_block_assembler_pkg::*;
#(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter  int PIX_W      = DEF_PIX_W,
  localparam int IDX_W      = clog2_min1(IMG_WIDTH * IMG_HEIGHT / 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] Data1,
  output logic [PIX_W-1:0] Data2,
  output logic [PIX_W-1:0] Data3,
  output logic [PIX_W-1:0] Data4,
  output logic             blk_valid,
  output logic             frame_done
`ifdef PBA_BLOCK_INDEX_EN
  ,
  output logic [IDX_W-1:0] blk_index
`endif
);

  localparam int COL_W  = clog2_min1(IMG_WIDTH);
  localparam int ROW_W  = clog2_min1(IMG_HEIGHT);
  localparam int DEPTH  = IMG_WIDTH / 2;
  localparam int ADDR_W = clog2_min1(DEPTH);

  logic [COL_W-1:0]          col_q, col_e, col_next;
  logic [ROW_W-1:0]          row_q, row_e, row_next;
  logic [PIX_W-1:0]          hold_q;
  logic [2*PIX_W-1:0]        pair_rd;
  logic [ADDR_W-1:0]         pair_addr;
  logic [3:0][PIX_W-1:0]     blk_q;
  logic                      blk_valid_q, frame_done_q;
  logic                      wr_en, blk_load, last_col, last_row;

  // sof relabels the current pixel as (0,0); everything downstream uses col_e/row_e.
  always_comb begin
    col_e     = sof ? '0 : col_q;
    row_e     = sof ? '0 : row_q;
    last_col  = (col_e == COL_W'(IMG_WIDTH - 1));
    last_row  = (row_e == ROW_W'(IMG_HEIGHT - 1));
    col_next  = last_col ? '0 : col_e + 1'b1;
    row_next  = row_e;
    if (last_col) row_next = last_row ? '0 : row_e + 1'b1;
    wr_en     = pix_valid & ~row_e[0] & col_e[0];
    blk_load  = pix_valid &  row_e[0] & col_e[0];
    pair_addr = ADDR_W'(col_e >> 1);
  end

  pair_line_buf #(
    .DEPTH  (DEPTH),
    .WIDTH  (2 * PIX_W),
    .ADDR_W (ADDR_W)
  ) u_pair_line_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (pair_addr),
    .wr_data ({hold_q, pix_in}),
    .rd_addr (pair_addr),
    .rd_data (pair_rd)
  );

  // NOTE: reset is synchronous and checked first, so a pixel arriving with rst
  // is dropped; all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      blk_q        <= '0;
      blk_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      blk_valid_q  <= blk_load;
      frame_done_q <= blk_load & last_row & last_col;
      if (pix_valid) begin
        col_q <= col_next;
        row_q <= row_next;
        if (!col_e[0]) hold_q <= pix_in;
      end
      if (blk_load) begin
        blk_q[BLK_TL] <= pair_rd[2*PIX_W-1:PIX_W];
        blk_q[BLK_TR] <= pair_rd[PIX_W-1:0];
        blk_q[BLK_BL] <= hold_q;
        blk_q[BLK_BR] <= pix_in;
      end
    end
  end

`ifdef PBA_BLOCK_INDEX_EN
  logic [IDX_W-1:0] blk_index_q;

  // Derived from position rather than counted, so sof restarts it for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_index_q <= '0;
    end else if (blk_load) begin
      blk_index_q <= IDX_W'(int'(row_e >> 1) * (IMG_WIDTH / 2) + int'(col_e >> 1));
    end
  end

  assign blk_index = blk_index_q;
`else
  // Without the index option the block position is not exported.
`endif

  assign Data1 = blk_q[BLK_TL];
  assign Data2 = blk_q[BLK_TR];
  assign Data3 = blk_q[BLK_BL];
  assign Data4 = blk_q[BLK_BR];

  // A strobe already registered when rst arrives must never be seen downstream.
  assign blk_valid  = blk_valid_q  & ~rst;
  assign frame_done = frame_done_q & ~rst;

endmodule

// File: tb/tb_pixel_block_assembler.sv
// Self-checking bench for pixel_block_assembler: an image-position model
// predicts every block, plus literal expectations for the directed streams.
module tb_pixel_block_assembler;

`ifdef PBA_BLOCK_INDEX_EN
  localparam int W = 8;
  localparam int H = 4;
`else
  localparam int W = 4;
  localparam int H = 2;
`endif
  localparam int IDX_W = (W * H / 4 <= 2) ? 1 : $clog2(W * H / 4);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] Data1, Data2, Data3, Data4;
  logic       blk_valid, frame_done;
`ifdef PBA_BLOCK_INDEX_EN
  logic [IDX_W-1:0] blk_index;
`endif

  pixel_block_assembler #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .Data1      (Data1),
    .Data2      (Data2),
    .Data3      (Data3),
    .Data4      (Data4),
    .blk_valid  (blk_valid),
    .frame_done (frame_done)
`ifdef PBA_BLOCK_INDEX_EN
    ,
    .blk_index  (blk_index)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frame image addressed by raster position; a block is due whenever
  // the accepted pixel sits on an odd row and odd column.
  logic [7:0]  img [W*H];
  int          m_pos = 0;
  logic        m_valid = 1'b0;
  logic        m_fd = 1'b0;
  logic [7:0]  m_d [4] = '{default: 8'h00};
  int          m_idx = 0;
  logic [31:0] mlog [$];
  int          p, r, c;

  assign p = sof ? 0 : m_pos;
  assign r = p / W;
  assign c = p % W;

  always @(posedge clk) begin
    if (rst) begin
      m_pos   <= 0;
      m_valid <= 1'b0;
      m_fd    <= 1'b0;
      m_d     <= '{default: 8'h00};
      m_idx   <= 0;
    end else begin
      m_valid <= 1'b0;
      m_fd    <= 1'b0;
      if (pix_valid) begin
        img[p] <= pix_in;
        m_pos  <= (p + 1) % (W * H);
        if (r % 2 == 1 && c % 2 == 1) begin
          m_valid <= 1'b1;
          m_fd    <= (p == W * H - 1);
          m_d[0]  <= img[p-W-1];
          m_d[1]  <= img[p-W];
          m_d[2]  <= img[p-1];
          m_d[3]  <= pix_in;
          m_idx   <= (r / 2) * (W / 2) + c / 2;
          mlog.push_back({img[p-W-1], img[p-W], img[p-1], pix_in});
        end
      end
    end
  end

  // Compare process: every cycle once the bench has released reset.
  bit          cmp_en = 1'b0;
  logic [31:0] dlog [$];
  int          ilog [$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("blk_valid", blk_valid, m_valid & ~rst);
      check("frame_done", frame_done, m_fd & ~rst);
      check("Data1", Data1, m_d[0]);
      check("Data2", Data2, m_d[1]);
      check("Data3", Data3, m_d[2]);
      check("Data4", Data4, m_d[3]);
`ifdef PBA_BLOCK_INDEX_EN
      if (m_valid) check("blk_index", blk_index, m_idx);
      if (blk_valid) ilog.push_back(int'(blk_index));
`endif
      if (blk_valid)  dlog.push_back({Data1, Data2, Data3, Data4});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send(input logic [7:0] v, input logic s);
    pix_in    = v;
    pix_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n, input logic s);
    sof = s;
    repeat (n) @(posedge clk);
    #1;
    sof = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input logic first_sof);
    for (int i = 0; i < W * H; i++) begin
      send(8'(base + i), (i == 0) ? first_sof : 1'b0);
      if (gap > 0) idle(gap, (i == 2) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic clear_logs();
    dlog.delete();
    mlog.delete();
    ilog.delete();
    fd_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_Data1", Data1, 0);
    check("reset_Data4", Data4, 0);
    check("reset_blk_valid", blk_valid, 0);
    #1;

    // Continuous frame 1..N.
    clear_logs();
    send_frame(1, 0, 1'b0);
    idle(3, 1'b0);
    check("t1_frame_done_count", fd_cnt, 1);
`ifndef PBA_BLOCK_INDEX_EN
    check("t1_pulse_count", dlog.size(), 2);
    check("t1_blk0", dlog[0], 32'h01020506);
    check("t1_blk1", dlog[1], 32'h03040708);
    check("t1_model_blk0", mlog[0], 32'h01020506);
    check("t1_model_blk1", mlog[1], 32'h03040708);
`else
    check("t1_pulse_count", ilog.size(), 8);
    for (int i = 0; i < 8; i++) check("t1_blk_index", ilog[i], i);
`endif

    // Gapped stream; a stray sof without pix_valid sits in one gap.
    clear_logs();
    send_frame(1, 1, 1'b0);
    idle(3, 1'b0);
    check("t2_frame_done_count", fd_cnt, 1);
`ifndef PBA_BLOCK_INDEX_EN
    check("t2_pulse_count", dlog.size(), 2);
    check("t2_blk0", dlog[0], 32'h01020506);
    check("t2_blk1", dlog[1], 32'h03040708);
`endif

    // Back-to-back frames, sof on the natural (0,0) pixel.
    clear_logs();
    send_frame(1, 0, 1'b1);
    send_frame(11, 0, 1'b1);
    idle(3, 1'b0);
    check("t3_frame_done_count", fd_cnt, 2);
`ifndef PBA_BLOCK_INDEX_EN
    check("t3_pulse_count", dlog.size(), 4);
    check("t3_blk2", dlog[2], 32'h0b0c0f10);
    check("t3_blk3", dlog[3], 32'h0d0e1112);
`else
    check("t3_index_wrap", ilog[8], 0);
`endif

    // Abort after five pixels with sof on pixel 21.
    clear_logs();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    send_frame(21, 0, 1'b1);
    idle(3, 1'b0);
`ifndef PBA_BLOCK_INDEX_EN
    check("t4_pulse_count", dlog.size(), 2);
    check("t4_blk0", dlog[0], 32'h1516191a);
    check("t4_blk1", dlog[1], 32'h17181b1c);
    check("t4_model_blk0", mlog[0], 32'h1516191a);
`endif

    // Reset right after pixel 6 is accepted: that block must never appear.
    clear_logs();
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    rst = 1'b1;
    idle(1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_Data1_cleared", Data1, 0);
    check("t5_Data2_cleared", Data2, 0);
    check("t5_Data3_cleared", Data3, 0);
    check("t5_Data4_cleared", Data4, 0);
    check("t5_no_pulse", dlog.size(), 0);
    #1;
    send_frame(1, 0, 1'b0);
    idle(3, 1'b0);
    check("t5_restart_frame_done", fd_cnt, 1);
`ifndef PBA_BLOCK_INDEX_EN
    check("t5_restart_pulses", dlog.size(), 2);
    check("t5_restart_blk0", dlog[0], 32'h01020506);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
